rtz_round_pipe: RTL

//  Parametrised, pipelined successor to the fixed 16-bit round-toward-zero unit. Rounds the

---
 rtl/mac_pkg.sv | 9 +
 rtl/rtz_round_core.sv | 31 +++
 rtl/rtz_round_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - rounding mode encodings shared by the round pipe and the MAC controller
package mac_pkg;
  typedef logic [1:0] rnd_mode_t;

  localparam rnd_mode_t RND_TRUNC = 2'd0;
  localparam rnd_mode_t RND_RTZ   = 2'd1;
  localparam rnd_mode_t RND_RHAZ  = 2'd2;
  localparam rnd_mode_t RND_RNE   = 2'd3;
endpackage

// File: rtl/rtz_round_core.sv
// rtl/rtz_round_core.sv - decides whether the truncated value gets bumped by one coarse LSB
module rtz_round_core
  import mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DROP_W = 2
) (
  input  logic [DATA_W-1:0] x,
  input  rnd_mode_t         mode,
  output logic              inc_en
);
  localparam logic [DROP_W-1:0] HALF = DROP_W'(1 << (DROP_W - 1));

  logic [DROP_W-1:0] low;
  logic              neg;
  logic              t_lsb;

  always_comb begin
    low    = x[DROP_W-1:0];
    neg    = x[DATA_W-1];
    t_lsb  = x[DROP_W];
    inc_en = 1'b0;
    case (mode)
      RND_TRUNC: inc_en = 1'b0;
      RND_RTZ:   inc_en = neg && (low != '0);
      RND_RHAZ:  inc_en = neg ? (low > HALF) : (low >= HALF);
      RND_RNE:   inc_en = (low > HALF) || ((low == HALF) && t_lsb);
      default:   inc_en = 1'b0;
    endcase
  end
endmodule

// File: rtl/rtz_round_pipe.sv
// rtl/rtz_round_pipe.sv - two-stage rounding pipe with saturation, valid/ready on both sides
module rtz_round_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DROP_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  rnd_mode_t         in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  input  logic              sat_clr,
  output logic [CNT_W-1:0]  sat_count
);
  generate
    if (DROP_W < 1 || DROP_W > DATA_W - 2) begin : g_bad_drop_w
      $error("rtz_round_pipe: DROP_W must be in 1..DATA_W-2");
    end
  endgenerate

  localparam logic [DATA_W-1:0] SAT_VAL = {1'b0, {(DATA_W-1-DROP_W){1'b1}}, {DROP_W{1'b0}}};
  localparam logic [DATA_W:0]   INC_VAL = (DATA_W+1)'(1) << DROP_W;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_x_q, s1_x_d;
  rnd_mode_t         s1_mode_q, s1_mode_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic [CNT_W-1:0]  sat_count_q, sat_count_d;

  logic              inc_en;
  logic              s2_load;
  logic              s1_advance;
  logic              in_fire;
  logic [DATA_W-1:0] trunc_x;
  logic [DATA_W:0]   sum;
  logic              ovf;

  rtz_round_core #(
    .DATA_W (DATA_W),
    .DROP_W (DROP_W)
  ) u_core (
    .x      (s1_x_q),
    .mode   (s1_mode_q),
    .inc_en (inc_en)
  );

  always_comb begin
    s2_load    = !out_valid_q || out_ready;
    s1_advance = s1_valid_q && s2_load;
    in_ready   = !s1_valid_q || s1_advance;
    in_fire    = in_valid && in_ready;

    // The bump only ever moves toward +inf, so only positive overflow is possible.
    trunc_x = {s1_x_q[DATA_W-1:DROP_W], {DROP_W{1'b0}}};
    sum     = {trunc_x[DATA_W-1], trunc_x} + (inc_en ? INC_VAL : '0);
    ovf     = sum[DATA_W] != sum[DATA_W-1];

    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_mode_d  = s1_mode_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_x_d     = in_data;
      s1_mode_d  = in_mode;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = ovf ? SAT_VAL : sum[DATA_W-1:0];
        out_sat_d  = ovf;
      end
    end

    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_valid_q && out_ready && out_sat_q && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_mode_q   <= RND_TRUNC;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;
endmodule
